// File: rtl/stepper_ramp_gen.sv
// stepper_ramp_gen: step/dir pulse generator with optional trapezoidal ramp.
//
// Accepts a signed step count and a half-period profile. It drives step/dir to an
// external driver chip, reports the signed remaining count, and supports abort.
//
// Configuration macro: STEPPER_RAMP_EN
//   defined   - trapezoidal accel/decel using accel_dec_i
//   undefined - every step uses the effective minimum half-period; accel_dec_i ignored
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         single-cycle start request (sampled only when idle)
//   abort_i         stop motion immediately
//   steps_in_i      signed step count, MSB = direction
//   start_half_i    initial (slowest) half-period in clk cycles
//   min_half_i      cruise (fastest) half-period in clk cycles
//   accel_dec_i     half-period change per step while ramping
//   step_signal_o   step pulse
//   dir_o           direction (MSB of latched count)
//   busy_o          motion in progress
//   done_o          one-cycle pulse at end of motion
//   steps_left_o    signed steps remaining
module stepper_ramp_gen #(
  parameter int unsigned STEP_W    = 32,
  parameter int unsigned PER_W     = 24,
  parameter int unsigned DIR_SETUP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] steps_in_i,
  input  logic [PER_W-1:0]  start_half_i,
  input  logic [PER_W-1:0]  min_half_i,
  input  logic [PER_W-1:0]  accel_dec_i,
  output logic              step_signal_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] steps_left_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_e;

  localparam logic [PER_W-1:0]  PerOne    = PER_W'(1);
  localparam logic [STEP_W-1:0] StepOne   = STEP_W'(1);
  localparam logic [PER_W-1:0]  SetupLoad = PER_W'(DIR_SETUP - 1);

  state_e            state_q, state_d;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] mag_q, mag_d;
  logic [PER_W-1:0]  half_q, half_d;
  logic [PER_W-1:0]  min_q, min_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] steps_left_q, steps_left_d;

  // Latch-time sanitising: zero half-periods become 1, cruise never slower than start.
  logic [STEP_W-1:0] mag_in;
  logic [PER_W-1:0]  sh_san, mh_san, eff_min;
  logic [STEP_W-1:0] mag_dec;
  logic [PER_W-1:0]  half_next;

  assign mag_in  = steps_in_i[STEP_W-1] ? (STEP_W'(0) - steps_in_i) : steps_in_i;
  assign sh_san  = (start_half_i == '0) ? PerOne : start_half_i;
  assign mh_san  = (min_half_i == '0) ? PerOne : min_half_i;
  assign eff_min = (mh_san < sh_san) ? mh_san : sh_san;
  assign mag_dec = mag_q - StepOne;

`ifdef STEPPER_RAMP_EN
  logic [PER_W-1:0]  start_q, start_d;
  logic [PER_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] ramp_q, ramp_d;
  logic [STEP_W-1:0] ramp_next;
  logic [PER_W:0]    half_up, half_dn;

  // Extra bit keeps add/subtract from wrapping before clamping.
  always_comb begin
    half_up   = {1'b0, half_q} + {1'b0, acc_q};
    half_dn   = {1'b0, half_q} - {1'b0, acc_q};
    half_next = half_q;
    ramp_next = ramp_q;
    if (mag_dec <= ramp_q) begin
      half_next = (half_up > {1'b0, start_q}) ? start_q : half_up[PER_W-1:0];
      if (ramp_q != '0) ramp_next = ramp_q - StepOne;
    end else if (half_q > min_q) begin
      half_next = (half_dn[PER_W] || (half_dn[PER_W-1:0] < min_q)) ? min_q
                                                                   : half_dn[PER_W-1:0];
      ramp_next = ramp_q + StepOne;
    end
  end
`else
  logic unused_accel;
  assign unused_accel = ^accel_dec_i;
  assign half_next    = half_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    half_d  = half_q;
    min_d   = min_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
`ifdef STEPPER_RAMP_EN
    start_d = start_q;
    acc_d   = acc_q;
    ramp_d  = ramp_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          mag_d = mag_in;
          min_d = eff_min;
`ifdef STEPPER_RAMP_EN
          half_d  = sh_san;
          start_d = sh_san;
          acc_d   = accel_dec_i;
          ramp_d  = '0;
`else
          half_d = eff_min;
`endif
          if (mag_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StSetup;
            dir_d   = steps_in_i[STEP_W-1];
            cnt_d   = SetupLoad;
          end
        end
      end
      StSetup: begin
        if (abort_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StHigh;
          cnt_d   = half_q - PerOne;
        end else begin
          cnt_d = cnt_q - PerOne;
        end
      end
      StHigh: begin
        if (abort_i) begin
          // The step edge already went out, so it counts.
          state_d = StIdle;
          done_d  = 1'b1;
          mag_d   = mag_dec;
        end else if (cnt_q == '0) begin
          state_d = StLow;
          cnt_d   = half_q - PerOne;
        end else begin
          cnt_d = cnt_q - PerOne;
        end
      end
      StLow: begin
        if (abort_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          mag_d = mag_dec;
          if (mag_dec == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StHigh;
            half_d  = half_next;
            cnt_d   = half_next - PerOne;
`ifdef STEPPER_RAMP_EN
            ramp_d = ramp_next;
`endif
          end
        end else begin
          cnt_d = cnt_q - PerOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Remaining count lags mag by one cycle.
  assign steps_left_d = dir_q ? (STEP_W'(0) - mag_q) : mag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mag_q        <= '0;
      half_q       <= '0;
      min_q        <= '0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
`ifdef STEPPER_RAMP_EN
      start_q <= '0;
      acc_q   <= '0;
      ramp_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mag_q        <= mag_d;
      half_q       <= half_d;
      min_q        <= min_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      steps_left_q <= steps_left_d;
`ifdef STEPPER_RAMP_EN
      start_q <= start_d;
      acc_q   <= acc_d;
      ramp_q  <= ramp_d;
`endif
    end
  end

  assign step_signal_o = (state_q == StHigh);
  assign busy_o        = (state_q != StIdle);
  assign dir_o         = dir_q;
  assign done_o        = done_q;
  assign steps_left_o  = steps_left_q;

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Directed bench for stepper_ramp_gen (STEP_W=32, PER_W=24, DIR_SETUP=4).
module tb_stepper_ramp_gen;

  localparam int MaxP = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] steps_in;
  logic [23:0] start_half;
  logic [23:0] min_half;
  logic [23:0] accel_dec;
  logic        step_signal;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] steps_left;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the last run_move
  int          n_pulses;
  int          first_edge;
  int          high_len [MaxP];
  int          low_len  [MaxP];
  logic [31:0] sl_fall  [MaxP];
  bit          got_done;
  logic        busy_at_done;
  logic        busy_before_done;
  logic        busy1;
  logic        dir1;
  logic [31:0] sl_after;
  logic        done_after;

  stepper_ramp_gen #(
    .STEP_W   (32),
    .PER_W    (24),
    .DIR_SETUP(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .steps_in_i   (steps_in),
    .start_half_i (start_half),
    .min_half_i   (min_half),
    .accel_dec_i  (accel_dec),
    .step_signal_o(step_signal),
    .dir_o        (dir),
    .busy_o       (busy),
    .done_o       (done),
    .steps_left_o (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a move at cycle 0 and record the pulse train until done or budget expiry.
  task automatic run_move(input int steps, input int sh, input int mh, input int acc,
                          input int budget);
    logic prev;
    int   hl;
    int   ll;
    n_pulses = 0; first_edge = -1; got_done = 0;
    busy_at_done = 1'bx; busy_before_done = 1'b0;
    for (int i = 0; i < MaxP; i++) begin
      high_len[i] = -1; low_len[i] = -1; sl_fall[i] = 'x;
    end
    steps_in = 32'(steps); start_half = 24'(sh); min_half = 24'(mh); accel_dec = 24'(acc);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy1 = busy; dir1 = dir;
    prev = 1'b0; hl = 0; ll = 0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) tick();
      if (done) begin
        got_done = 1;
        busy_at_done = busy;
        if (n_pulses > 0 && n_pulses <= MaxP) low_len[n_pulses-1] = ll;
        break;
      end
      busy_before_done = busy;
      if (step_signal) begin
        if (!prev) begin
          if (first_edge < 0) first_edge = c;
          if (n_pulses > 0 && n_pulses <= MaxP) low_len[n_pulses-1] = ll;
          n_pulses++;
          hl = 0;
        end
        hl++;
      end else begin
        if (prev && n_pulses <= MaxP) begin
          high_len[n_pulses-1] = hl;
          sl_fall[n_pulses-1]  = steps_left;
        end
        ll++;
        if (prev) ll = 1;
      end
      prev = step_signal;
    end
    tick();
    sl_after = steps_left; done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    steps_in = '0; start_half = '0; min_half = '0; accel_dec = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({step_signal, dir, busy, done} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {step_signal, dir, busy, done});
    else n_pass++;
    n_checks++;
    if (steps_left !== 32'd0) $display("FAIL reset_steps_left: got %0d want 0", steps_left);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_move();
    run_move(3, 2, 2, 0, 100);
    n_checks++;
    if (busy1 !== 1'b1 || dir1 !== 1'b0)
      $display("FAIL basic_start: busy/dir got %b%b want 10", busy1, dir1);
    else n_pass++;
    n_checks++;
    if (first_edge !== 5) $display("FAIL basic_first_edge: got %0d want 5", first_edge);
    else n_pass++;
    n_checks++;
    if (n_pulses !== 3) $display("FAIL basic_pulses: got %0d want 3", n_pulses);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (high_len[k] !== 2 || low_len[k] !== 2 || sl_fall[k] !== 32'(3 - k))
        $display("FAIL basic_step%0d: high %0d low %0d left %0d want 2 2 %0d",
                 k, high_len[k], low_len[k], $signed(sl_fall[k]), 3 - k);
      else n_pass++;
    end
    n_checks++;
    if (!got_done || busy_at_done !== 1'b0 || busy_before_done !== 1'b1)
      $display("FAIL basic_done: done %0d busy_at %b busy_before %b want 1 0 1",
               got_done, busy_at_done, busy_before_done);
    else n_pass++;
    n_checks++;
    if (sl_after !== 32'd0 || done_after !== 1'b0)
      $display("FAIL basic_after: left %0d done %b want 0 0", sl_after, done_after);
    else n_pass++;
  endtask

  task automatic test_negative_move();
    run_move(-5, 2, 2, 0, 100);
    n_checks++;
    if (dir1 !== 1'b1) $display("FAIL neg_dir: got %b want 1", dir1);
    else n_pass++;
    n_checks++;
    if (n_pulses !== 5) $display("FAIL neg_pulses: got %0d want 5", n_pulses);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (sl_fall[k] !== 32'(-5 + k))
        $display("FAIL neg_left%0d: got %0d want %0d", k, $signed(sl_fall[k]), -5 + k);
      else n_pass++;
    end
    n_checks++;
    if (!got_done || sl_after !== 32'd0)
      $display("FAIL neg_done: done %0d left %0d want 1 0", got_done, $signed(sl_after));
    else n_pass++;
  endtask

  task automatic test_ramp_trapezoid();
`ifdef STEPPER_RAMP_EN
    int exp_h[10] = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
`else
    int exp_h[10] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
`endif
    run_move(10, 10, 4, 2, 400);
    n_checks++;
    if (n_pulses !== 10 || !got_done)
      $display("FAIL trap_pulses: got %0d done %0d want 10 1", n_pulses, got_done);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (high_len[k] !== exp_h[k] || low_len[k] !== exp_h[k])
        $display("FAIL trap_half%0d: high %0d low %0d want %0d", k, high_len[k], low_len[k],
                 exp_h[k]);
      else n_pass++;
    end
  endtask

  task automatic test_ramp_triangle();
`ifdef STEPPER_RAMP_EN
    int exp_h[3] = '{10, 8, 10};
`else
    int exp_h[3] = '{4, 4, 4};
`endif
    run_move(3, 10, 4, 2, 200);
    n_checks++;
    if (n_pulses !== 3) $display("FAIL tri_pulses: got %0d want 3", n_pulses);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (high_len[k] !== exp_h[k] || low_len[k] !== exp_h[k])
        $display("FAIL tri_half%0d: high %0d low %0d want %0d", k, high_len[k], low_len[k],
                 exp_h[k]);
      else n_pass++;
    end
  endtask

  task automatic test_sanitise();
    // Zero half-periods behave as 1.
    run_move(2, 0, 0, 0, 50);
    n_checks++;
    if (n_pulses !== 2 || high_len[0] !== 1 || low_len[0] !== 1 || high_len[1] !== 1)
      $display("FAIL zero_half: pulses %0d high %0d low %0d want 2 1 1",
               n_pulses, high_len[0], low_len[0]);
    else n_pass++;
    // min_half slower than start_half: start_half wins.
    run_move(2, 3, 5, 1, 50);
    n_checks++;
    if (n_pulses !== 2 || high_len[0] !== 3 || high_len[1] !== 3 || low_len[1] !== 3)
      $display("FAIL min_swap: pulses %0d high %0d/%0d low %0d want 2 3/3 3",
               n_pulses, high_len[0], high_len[1], low_len[1]);
    else n_pass++;
  endtask

  task automatic test_abort();
    // Abort in HIGH of step 2 of 6: step counts, 4 remain.
    steps_in = 32'd6; start_half = 24'd2; min_half = 24'd2; accel_dec = 24'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (step_signal !== 1'b1) $display("FAIL abort_pre_high: got %b want 1", step_signal);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({step_signal, busy, done} !== 3'b001)
      $display("FAIL abort_high: step/busy/done got %b want 001", {step_signal, busy, done});
    else n_pass++;
    tick();
    n_checks++;
    if (steps_left !== 32'd4 || done !== 1'b0)
      $display("FAIL abort_high_left: left %0d done %b want 4 0", steps_left, done);
    else n_pass++;
    // Abort in SETUP: nothing counted.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({step_signal, busy, done} !== 3'b001)
      $display("FAIL abort_setup: step/busy/done got %b want 001", {step_signal, busy, done});
    else n_pass++;
    tick();
    n_checks++;
    if (steps_left !== 32'd6) $display("FAIL abort_setup_left: got %0d want 6", steps_left);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    steps_in = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_done: done %b busy %b want 1 0", done, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || steps_left !== 32'd0)
      $display("FAIL zero_after: done %b busy %b left %0d want 0 0 0", done, busy, steps_left);
    else n_pass++;
  endtask

  task automatic test_start_with_abort();
    steps_in = 32'd4;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_abort_idle: busy %b done %b want 0 0", busy, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_move();
    steps_in = -32'sd7; start_half = 24'd2; min_half = 24'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (step_signal !== 1'b1 || dir !== 1'b1 || steps_left !== -32'sd7)
      $display("FAIL mid_pre: step %b dir %b left %0d want 1 1 -7",
               step_signal, dir, $signed(steps_left));
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({step_signal, dir, busy, done} !== 4'b0000 || steps_left !== 32'd0)
      $display("FAIL mid_reset: flags %b left %0d want 0000 0",
               {step_signal, dir, busy, done}, steps_left);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_release: done %b busy %b want 0 0", done, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_negative_move();
    test_ramp_trapezoid();
    test_ramp_triangle();
    test_sanitise();
    test_abort();
    test_zero_count();
    test_start_with_abort();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
